tdm_slot_scheduler: RTL

Four-lane time-division scheduler that builds the serialized 9-bit word stream consumed by the lane demultiplexer. Each lane buffers incoming payload words in its own FIFO. The block drives a fixed rotation of slots 0,1,2,3 on `clk_4f`, with one slot per lane. In a slot whose lane has data, it emits that lane's oldest word with the valid bit (bit 8) set; otherwise it emits an idle word. It also sequences start-up alignment and clean frame-boundary shutdown, so slot k always lands on demux output k.

---
 rtl/tdm_slot_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/tdm_slot_scheduler.sv
// rtl/tdm_slot_scheduler.sv - four-lane TDM slot scheduler with per-lane FIFOs
// Optional per-lane idle-slot counters are built when SCHED_STATS_EN is defined.
module tdm_slot_scheduler #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int ALIGN_FRAMES = 1
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic [WIDTH:0]   out_word,
  output logic [1:0]       slot,
  output logic             frame_start,
  output logic             busy
`ifdef SCHED_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [7:0]       idle_cnt0,
  output logic [7:0]       idle_cnt1,
  output logic [7:0]       idle_cnt2,
  output logic [7:0]       idle_cnt3
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] ALIGN_LAST = 16'(ALIGN_FRAMES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ALIGN = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [WIDTH-1:0] mem [4][DEPTH];
  logic [AW-1:0]    wr_ptr [4];
  logic [AW-1:0]    rd_ptr [4];
  logic [CW-1:0]    count [4];
  logic [WIDTH-1:0] lane_data [4];
  logic [3:0]       push;
  logic [3:0]       pop;

  logic [1:0]       state, state_d;
  logic [1:0]       slot_d;
  logic [WIDTH:0]   word_d;
  logic             fs_d;
  logic [15:0]      align_cnt, align_d;

  assign lane_data[0] = in_data0;
  assign lane_data[1] = in_data1;
  assign lane_data[2] = in_data2;
  assign lane_data[3] = in_data3;

  // A full lane stays not-ready even while being popped: no pass-through.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      in_ready[k] = (count[k] != CW'(DEPTH));
    end
  end

  assign push = in_valid & in_ready;

  always_comb begin
    state_d = state;
    slot_d  = slot + 2'd1;
    align_d = align_cnt;
    word_d  = '0;
    pop     = '0;
    case (state)
      ST_IDLE: begin
        slot_d  = 2'd0;
        align_d = '0;
        if (enable) state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (slot == 2'd3) begin
          if (!enable)                      state_d = ST_IDLE;
          else if (align_cnt == ALIGN_LAST) state_d = ST_RUN;
          else                              align_d = align_cnt + 16'd1;
        end
      end
      ST_RUN: begin
        if (slot == 2'd3 && !enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) slot_d = 2'd0;
    fs_d = (state_d != ST_IDLE) && (slot_d == 2'd0);
    // Counts are pre-edge, so a word pushed this cycle cannot be emitted now.
    if (state_d == ST_RUN && count[slot_d] != '0) begin
      pop[slot_d] = 1'b1;
      word_d      = {1'b1, mem[slot_d][rd_ptr[slot_d]]};
    end
  end

  always_ff @(posedge clk_4f) begin
    for (int k = 0; k < 4; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= lane_data[k];
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        count[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + 1'b1;
          2'b01:   count[k] <= count[k] - 1'b1;
          default: count[k] <= count[k];
        endcase
      end
    end
  end

  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      slot        <= '0;
      out_word    <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      align_cnt   <= '0;
    end else begin
      state       <= state_d;
      slot        <= slot_d;
      out_word    <= word_d;
      frame_start <= fs_d;
      busy        <= (state_d != ST_IDLE);
      align_cnt   <= align_d;
    end
  end

`ifdef SCHED_STATS_EN
  logic [7:0] idle_cnt [4];
  logic [3:0] idle_hit;

  always_comb begin
    idle_hit = '0;
    if (state_d == ST_RUN && count[slot_d] == '0) idle_hit[slot_d] = 1'b1;
  end

  // Clear takes priority over a same-cycle increment; counters saturate.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) idle_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (stats_clr)                                idle_cnt[k] <= '0;
        else if (idle_hit[k] && idle_cnt[k] != 8'hFF) idle_cnt[k] <= idle_cnt[k] + 8'd1;
      end
    end
  end

  assign idle_cnt0 = idle_cnt[0];
  assign idle_cnt1 = idle_cnt[1];
  assign idle_cnt2 = idle_cnt[2];
  assign idle_cnt3 = idle_cnt[3];
`endif
endmodule
